// File: rtl/text_marquee_ctrl.sv
// Frame-rate sequencer for the text overlay: slides each message in from the
// right edge, holds it, slides it back out, then advances to the next message.
module text_marquee_ctrl #(
  parameter int NUM_MSG     = 4,
  parameter int MSG_W       = 2,
  parameter int START_CX    = 80,
  parameter int TARGET_CX   = 11,
  parameter int ROW_CY      = 38,
  parameter int SPEED_DIV   = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             en,
  input  logic             next_req,
  output logic [MSG_W-1:0] msg_sel,
  output logic [6:0]       org_cx,
  output logic [5:0]       org_cy,
  output logic             overlay_en,
  output logic [1:0]       phase
);

  localparam int DIV_W  = (SPEED_DIV   > 1) ? $clog2(SPEED_DIV)   : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [6:0]        CX_START = 7'(START_CX);
  localparam logic [6:0]        CX_TGT   = 7'(TARGET_CX);
  localparam logic [5:0]        CY_ROW   = 6'(ROW_CY);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SPEED_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [MSG_W-1:0]  MSG_LAST = MSG_W'(NUM_MSG - 1);

  generate
    if (!(TARGET_CX < START_CX && START_CX < 128 && NUM_MSG >= 1 &&
          NUM_MSG <= (1 << MSG_W) && SPEED_DIV >= 1 && HOLD_FRAMES >= 1)) begin : g_bad_param
      $error("text_marquee_ctrl: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IN   = 2'd1,
    S_HOLD = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [MSG_W-1:0]    r_msg,   w_msg;
  logic [6:0]          r_cx,    w_cx;
  logic [5:0]          r_cy;
  logic                r_ov,    w_ov;
  logic [DIV_W-1:0]    r_div,   w_div;
  logic [HOLD_W-1:0]   r_hold,  w_hold;
  logic                r_skip,  w_skip;
  logic                w_skip_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_msg   <= '0;
      r_cx    <= CX_START;
      r_cy    <= CY_ROW;
      r_ov    <= 1'b0;
      r_div   <= '0;
      r_hold  <= '0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_msg   <= w_msg;
      r_cx    <= w_cx;
      r_cy    <= CY_ROW;
      r_ov    <= w_ov;
      r_div   <= w_div;
      r_hold  <= w_hold;
      r_skip  <= w_skip;
    end
  end

  // A request landing on the frame_start edge itself is honoured on that edge.
  assign w_skip_now = r_skip | next_req;

  always_comb begin
    w_state = r_state;
    w_msg   = r_msg;
    w_cx    = r_cx;
    w_ov    = r_ov;
    w_div   = r_div;
    w_hold  = r_hold;
    w_skip  = frame_start ? 1'b0 : w_skip_now;

    if (frame_start) begin
      if (!en) begin
        w_state = S_IDLE;
        w_cx    = CX_START;
        w_ov    = 1'b0;
        w_div   = '0;
        w_hold  = '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            w_state = S_IN;
            w_cx    = CX_START;
            w_div   = '0;
            w_ov    = 1'b1;
          end
          S_IN: begin
            if (w_skip_now) begin
              w_state = S_OUT;
              w_div   = '0;
            end else if (r_div == DIV_MAX) begin
              w_div = '0;
              w_cx  = r_cx - 7'd1;
              if (r_cx - 7'd1 == CX_TGT) begin
                w_state = S_HOLD;
                w_hold  = '0;
              end
            end else begin
              w_div = r_div + 1'b1;
            end
          end
          S_HOLD: begin
            if (w_skip_now || r_hold == HOLD_MAX) begin
              w_state = S_OUT;
              w_div   = '0;
            end else begin
              w_hold = r_hold + 1'b1;
            end
          end
          S_OUT: begin
            if (r_div == DIV_MAX) begin
              w_div = '0;
              w_cx  = r_cx + 7'd1;
              if (r_cx + 7'd1 == CX_START) begin
                w_state = S_IN;
                w_msg   = (r_msg == MSG_LAST) ? '0 : r_msg + 1'b1;
              end
            end else begin
              w_div = r_div + 1'b1;
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
    end
  end

  assign msg_sel    = r_msg;
  assign org_cx     = r_cx;
  assign org_cy     = r_cy;
  assign overlay_en = r_ov;
  assign phase      = r_state;

endmodule

// File: tb/tb_text_marquee_ctrl.sv
// Directed bench for text_marquee_ctrl with default parameters; expected
// values are hand-derived frame counts (2 frames per cell, 60-frame hold).
module tb_text_marquee_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       en;
  logic       next_req;
  logic [1:0] msg_sel;
  logic [6:0] org_cx;
  logic [5:0] org_cy;
  logic       overlay_en;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  text_marquee_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .en         (en),
    .next_req   (next_req),
    .msg_sel    (msg_sel),
    .org_cx     (org_cx),
    .org_cy     (org_cy),
    .overlay_en (overlay_en),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
  endtask

  task automatic req_pulse();
    @(negedge clk) next_req = 1'b1;
    @(negedge clk) next_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; en = 1'b0; next_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_cx", org_cx, 80);
    chk("rst_cy", org_cy, 38);
    chk("rst_ov", overlay_en, 0);
    chk("rst_msg", msg_sel, 0);
    rst_n = 1'b1;

    en = 1'b1;
    fs(1);
    chk("start_phase", phase, 1);
    chk("start_cx", org_cx, 80);
    chk("start_ov", overlay_en, 1);
    chk("start_msg", msg_sel, 0);
    fs(2);
    chk("first_step_cx", org_cx, 79);

    fs(136);
    chk("in_done_cx", org_cx, 11);
    chk("in_done_phase", phase, 2);
    fs(59);
    chk("hold_last_phase", phase, 2);
    fs(1);
    chk("hold_exit_phase", phase, 3);
    chk("hold_exit_cx", org_cx, 11);
    fs(137);
    chk("out_near_cx", org_cx, 79);
    chk("out_near_phase", phase, 3);
    fs(1);
    chk("out_done_cx", org_cx, 80);
    chk("out_done_phase", phase, 1);
    chk("msg_1", msg_sel, 1);

    fs(336);
    chk("msg_2", msg_sel, 2);
    fs(336);
    chk("msg_3", msg_sel, 3);
    fs(336);
    chk("msg_wrap", msg_sel, 0);
    chk("wrap_phase", phase, 1);
    chk("wrap_cx", org_cx, 80);
    chk("cy_const", org_cy, 38);

    // Skip from HOLD, then a request in SLIDE_OUT that must not disturb it.
    fs(138);
    chk("hold2_phase", phase, 2);
    fs(10);
    req_pulse();
    chk("skip_pending_phase", phase, 2);
    fs(1);
    chk("skip_phase", phase, 3);
    chk("skip_cx", org_cx, 11);
    req_pulse();
    fs(1);
    chk("out_req_cx", org_cx, 11);
    chk("out_req_phase", phase, 3);
    fs(1);
    chk("out_req_step_cx", org_cx, 12);
    fs(136);
    chk("skip_cycle_cx", org_cx, 80);
    chk("skip_cycle_phase", phase, 1);
    chk("skip_cycle_msg", msg_sel, 1);

    // Disable mid SLIDE_IN with a coincident next_req.
    fs(60);
    chk("mid_in_cx", org_cx, 50);
    @(negedge clk) begin frame_start = 1'b1; en = 1'b0; next_req = 1'b1; end
    @(negedge clk) begin frame_start = 1'b0; next_req = 1'b0; end
    chk("dis_phase", phase, 0);
    chk("dis_ov", overlay_en, 0);
    chk("dis_cx", org_cx, 80);
    chk("dis_msg", msg_sel, 1);
    en = 1'b1;
    fs(1);
    chk("reen_phase", phase, 1);
    fs(1);
    chk("reen_noskip_phase", phase, 1);
    chk("reen_noskip_cx", org_cx, 80);

    // Asynchronous reset in the middle of SLIDE_OUT.
    fs(1);
    fs(136);
    chk("hold3_phase", phase, 2);
    fs(60);
    fs(20);
    chk("pre_rst_phase", phase, 3);
    chk("pre_rst_cx", org_cx, 21);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_cx", org_cx, 80);
    chk("arst_ov", overlay_en, 0);
    chk("arst_msg", msg_sel, 0);
    chk("arst_cy", org_cy, 38);
    @(negedge clk) rst_n = 1'b1;
    fs(1);
    chk("post_rst_phase", phase, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_marquee_ctrl.md
Name: text_marquee_ctrl

Overview:
Per-frame sequencer for the character-cell text overlays. It decides which of NUM_MSG messages is shown and where its cell origin sits. Each message slides in from the right edge, holds, slides back out, then the next message follows. The block sits between the VGA timing generator (frame pulse) and the overlay bitmap blocks, which consume msg_sel/org_cx/org_cy/overlay_en. Outputs change only on frame boundaries, so there is no mid-frame tearing.

Parameters:
NUM_MSG, 4, number of messages cycled (1..2^MSG_W)
MSG_W, 2, width of msg_sel
START_CX, 80, off-screen entry/exit cell column (7-bit)
TARGET_CX, 11, resting cell column; must be < START_CX
ROW_CY, 38, fixed cell row driven on org_cy
SPEED_DIV, 2, frame_start pulses per 1-cell step (>=1)
HOLD_FRAMES, 60, frame_start pulses spent in HOLD (>=1)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse per frame (start of vertical blank)
en  in  1  run enable; sampled only on frame_start
next_req  in  1  one-cycle request to skip to slide-out; any cycle
msg_sel  out  MSG_W  index of the message currently displayed
org_cx  out  7  overlay origin column in 8-px cells
org_cy  out  6  overlay origin row in 8-px cells (constant ROW_CY)
overlay_en  out  1  overlay visible
phase  out  2  0=IDLE 1=SLIDE_IN 2=HOLD 3=SLIDE_OUT

Behaviour:
- Reset (async on rst_n low): state IDLE, msg_sel=0, org_cx=START_CX, org_cy=ROW_CY, overlay_en=0, div_cnt=0, hold_cnt=0, skip_pend=0. Reset mid-slide aborts immediately; no state survives.
- All outputs are registered. State updates only on a clk edge where frame_start=1, except skip_pend. Outputs are valid the cycle after frame_start.
- skip_pend is set by next_req on any cycle. It is cleared on the next frame_start, whether or not it was consumed. next_req coincident with frame_start is consumed on that same frame_start.
- Priority on each frame_start: en=0 first, then skip, then normal stepping.
- en=0 on frame_start, from any state: go to IDLE, org_cx=START_CX, overlay_en=0, div/hold counters cleared. msg_sel is retained.
- IDLE: if en=1 on frame_start, go to SLIDE_IN with org_cx=START_CX, div_cnt=0, overlay_en=1.
- SLIDE_IN:
  - If skip_pend, go to SLIDE_OUT with org_cx unchanged and div_cnt=0.
  - Otherwise div_cnt increments. When div_cnt==SPEED_DIV-1, org_cx decrements by 1 and div_cnt=0.
  - If that step makes org_cx==TARGET_CX, go to HOLD the same update with hold_cnt=0.
  - SPEED_DIV=1 steps on every frame.
- HOLD:
  - If skip_pend, go to SLIDE_OUT.
  - Otherwise hold_cnt increments. On the frame_start where hold_cnt==HOLD_FRAMES-1, go to SLIDE_OUT with div_cnt=0.
  - HOLD therefore spans exactly HOLD_FRAMES frame_starts.
- SLIDE_OUT:
  - Same divider as SLIDE_IN, but org_cx increments.
  - When org_cx reaches START_CX: msg_sel=(msg_sel+1) mod NUM_MSG (wraps NUM_MSG-1 to 0), state goes to SLIDE_IN, div_cnt=0, overlay_en stays 1.
  - skip_pend in SLIDE_OUT is discarded.
- overlay_en=1 in SLIDE_IN, HOLD and SLIDE_OUT; 0 in IDLE.
- org_cx never leaves [TARGET_CX, START_CX]; no wrap-around arithmetic.
- Counter widths: div_cnt and hold_cnt are wide enough for their parameter values. Synthesis-time check that TARGET_CX<START_CX<128 and NUM_MSG<=2^MSG_W.

Test Plan:
- Reset then en=1, one frame_start -> phase=1, org_cx=80, overlay_en=1, msg_sel=0. Then 2 frame_starts -> org_cx=79.
- Defaults, en=1, 138 further frame_starts -> org_cx=11, phase=2. 60 more -> phase=3. 138 more -> org_cx=80, phase=1, msg_sel=1.
- Run 4 full cycles -> msg_sel goes 0,1,2,3,0 (wrap). org_cy=38 throughout.
- next_req mid-HOLD, then frame_start -> phase=3, org_cx=11. next_req during SLIDE_OUT -> no effect, timing unchanged.
- en=0 at a frame_start during SLIDE_IN with org_cx=50 -> phase=0, overlay_en=0, org_cx=80, msg_sel unchanged. next_req on that same frame_start is ignored.
- rst_n pulsed low mid-SLIDE_OUT, asynchronous to clk -> outputs return to reset values immediately, with no clk edge needed.
